uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 39 +++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit and receive blocks.
//   - UART_CLK_FREQ / UART_BAUD_RATE : default core clock and line rate.
//   - UART_DATA_BITS                 : payload bits per 8N1 frame.
//   - uart_rx_state_e                : receiver FSM states.
//   - uart_clks_per_bit()            : truncating clocks-per-bit divider.
package uart_pkg;

  localparam int unsigned UART_CLK_FREQ  = 100_000_000;
  localparam int unsigned UART_BAUD_RATE = 115_200;
  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;

  // Whole core clocks per serial bit; the fractional part is dropped.
  function automatic int unsigned uart_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Brings the asynchronous serial line into the core clock domain and
//   flags falling edges of the synchronised level.
//   Ports:
//     clk_i        in  core clock
//     rst_ni       in  async active-low reset
//     rx_i         in  raw serial line (idle high, asynchronous)
//     rx_sync_o    out synchronised line level (resets to idle = 1)
//     fall_edge_o  out 1 for one cycle when the synchronised level goes 1->0
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_edge_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // All three flops reset to the idle-line level so that releasing reset
  // can never manufacture a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign rx_sync_o   = sync_q;
  assign fall_edge_o = hist_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 asynchronous serial receiver. Each bit is sampled at its centre
//   using a baud counter started from the synchronised start edge; received
//   bytes are offered on a single-entry valid/ready holding register.
//   Ports:
//     sys_clk_i         in  core clock
//     sys_rstn_i        in  async active-low reset
//     uart_rx_i         in  serial line, idle high, asynchronous
//     uart_dat_o        out received byte, meaningful while uart_valid_o=1
//     uart_valid_o      out holding register full
//     uart_ready_i      in  consumer takes the byte on valid&ready
//     uart_frame_err_o  out one-cycle pulse: stop bit sampled low
//     uart_overrun_o    out one-cycle pulse: completed byte dropped (register full)
//     uart_busy_o       out receiver FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = UART_CLK_FREQ,
  parameter int unsigned BAUD_RATE    = UART_BAUD_RATE,
  parameter int unsigned CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ, BAUD_RATE),
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_ready_i,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o,
  output logic       uart_busy_o
);

  if (CLKS_PER_BIT < 4) begin : g_cfg_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic rx_sync;
  logic fall_edge;

  uart_rx_sync u_sync (
    .clk_i       (sys_clk_i),
    .rst_ni      (sys_rstn_i),
    .rx_i        (uart_rx_i),
    .rx_sync_o   (rx_sync),
    .fall_edge_o (fall_edge)
  );

  uart_rx_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dat_q, dat_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic half_tick;
  logic bit_tick;
  logic data_sample;
  logic stop_sample;
  logic byte_done;
  logic frame_bad;
  logic consume;

  // Counter events fire one cycle early so the registered action lands
  // exactly HALF_BIT / CLKS_PER_BIT cycles after the counter was cleared.
  assign half_tick   = (cnt_q == HALF_LAST);
  assign bit_tick    = (cnt_q == BIT_LAST);
  assign data_sample = (state_q == DATA) && bit_tick;
  assign stop_sample = (state_q == STOP) && bit_tick;
  assign byte_done   = stop_sample &&  rx_sync;
  assign frame_bad   = stop_sample && !rx_sync;
  assign consume     = valid_q && uart_ready_i;

  // FSM state register
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. STOP returns to IDLE at the stop-sample cycle,
  // half a bit early, so a following start bit with zero idle is caught.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall_edge) state_d = START;
      START: if (half_tick) state_d = rx_sync ? IDLE : DATA;
      DATA:  if (bit_tick && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:  if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output / datapath next-state logic
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    dat_d     = dat_q;
    valid_d   = valid_q;
    ferr_d    = frame_bad;
    ovr_d     = 1'b0;

    // Counter restarts on every state change and after each data sample;
    // it is parked at zero while idle.
    if ((state_d != state_q) || (state_q == IDLE) || data_sample) begin
      cnt_d = '0;
    end

    if ((state_d == DATA) && (state_q != DATA)) begin
      bit_idx_d = 3'd0;
    end

    // LSB arrives first, so shift in from the top.
    if (data_sample) begin
      shift_d   = {rx_sync, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end

    // A byte completing in the same cycle the old one is taken replaces it.
    if (byte_done) begin
      if (!valid_q || consume) begin
        dat_d   = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      dat_q     <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      dat_q     <= dat_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign uart_dat_o       = dat_q;
  assign uart_valid_o     = valid_q;
  assign uart_frame_err_o = ferr_q;
  assign uart_overrun_o   = ovr_q;
  assign uart_busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CLK_FREQ  = 11_520_000;
  localparam int BAUD_RATE = 115_200;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;      // 100 clocks per bit
  localparam int HALF      = CPB / 2;                   // 50
  localparam int DETECT    = 3;                         // sync + history
  localparam int STOP_AT   = DETECT + HALF + 9 * CPB;   // 953 after line falls
  localparam int GLITCH_AT = DETECT + HALF;             // start check
  localparam int K_GLITCH  = 0;
  localparam int K_BYTE    = 1;
  localparam int K_FERR    = 2;

  typedef struct {
    int         fall;
    int         fin;
    int         kind;
    logic [7:0] b;
  } frame_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] dat;
  logic       valid, ferr, ovr, busy;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .sys_clk_i        (clk),
    .sys_rstn_i       (rst_n),
    .uart_rx_i        (rx),
    .uart_dat_o       (dat),
    .uart_valid_o     (valid),
    .uart_ready_i     (ready),
    .uart_frame_err_o (ferr),
    .uart_overrun_o   (ovr),
    .uart_busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  frame_t     frames[$];
  logic [7:0] rx_log[$];
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         valid_cyc = 0;
  int         vrise     = -1;
  int         brise     = -1;
  logic       valid_prev = 1'b0;
  logic       busy_prev  = 1'b0;
  logic       rdy_prev   = 1'b0;

  // Behavioural model state: the holding register as seen by the consumer.
  logic       mvalid = 1'b0;
  logic [7:0] mdat   = 8'h00;
  logic       mbusy, mferr, movr, consume, done;
  logic [7:0] done_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] log_at(input int i);
    if (i >= 0 && i < rx_log.size()) return rx_log[i];
    return 8'hxx;
  endfunction

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame with the given bit period (in clocks); the line is
  // left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
    frames.push_back('{cyc, cyc + STOP_AT, stop_bit ? K_BYTE : K_FERR, b});
    rx = 1'b0;
    hold(period);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(period);
    end
    rx = stop_bit;
    hold(period);
  endtask

  // Model + per-cycle compare + observation counters (negedge sampling).
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mvalid = 1'b0;
        mdat   = 8'h00;
        frames.delete();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_ferr",  32'(ferr),  32'd0);
        chk("rst_ovr",   32'(ovr),   32'd0);
        chk("rst_dat",   32'(dat),   32'd0);
      end else begin
        mbusy   = 1'b0;
        mferr   = 1'b0;
        movr    = 1'b0;
        done    = 1'b0;
        done_b  = 8'h00;
        consume = mvalid && rdy_prev;
        foreach (frames[i]) begin
          if (cyc >= frames[i].fall + DETECT && cyc < frames[i].fin) mbusy = 1'b1;
          if (cyc == frames[i].fin) begin
            if (frames[i].kind == K_BYTE) begin
              done   = 1'b1;
              done_b = frames[i].b;
            end else if (frames[i].kind == K_FERR) begin
              mferr = 1'b1;
            end
          end
        end
        while (frames.size() > 0 && frames[0].fin < cyc) frames.delete(0);
        if (done) begin
          if (!mvalid || consume) begin
            mvalid = 1'b1;
            mdat   = done_b;
          end else begin
            movr = 1'b1;
          end
        end else if (consume) begin
          mvalid = 1'b0;
        end
        chk("valid", 32'(valid), 32'(mvalid));
        chk("busy",  32'(busy),  32'(mbusy));
        chk("ferr",  32'(ferr),  32'(mferr));
        chk("ovr",   32'(ovr),   32'(movr));
        if (mvalid) chk("dat", 32'(dat), 32'(mdat));
      end
      if (valid && ready) rx_log.push_back(dat);
      if (ferr) ferr_cnt++;
      if (ovr) ovr_cnt++;
      if (valid) valid_cyc++;
      if (valid && !valid_prev) vrise = cyc;
      if (busy && !busy_prev) brise = cyc;
      valid_prev = valid;
      busy_prev  = busy;
      rdy_prev   = ready;
    end
  end

  initial begin
    int f0, n0, e0, o0, v0;
    logic [7:0] pb;

    #1;
    chk("init_valid", 32'(valid), 32'd0);
    chk("init_busy",  32'(busy),  32'd0);
    chk("init_dat",   32'(dat),   32'd0);
    chk("init_ferr",  32'(ferr),  32'd0);
    chk("init_ovr",   32'(ovr),   32'd0);
    hold(4);
    rst_n = 1'b1;
    hold(10);

    // Single frame 0xA5 with ready held high.
    ready = 1'b1;
    n0 = rx_log.size(); e0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cyc; f0 = cyc;
    send_frame(8'hA5, CPB, 1'b1);
    hold(200);
    chk("a5_latency",   32'(vrise - f0), 32'd953);
    chk("a5_busy_rise", 32'(brise - f0), 32'd3);
    chk("a5_count",     32'(rx_log.size() - n0), 32'd1);
    chk("a5_byte",      32'(log_at(n0)), 32'h0A5);
    chk("a5_valid_len", 32'(valid_cyc - v0), 32'd1);
    chk("a5_no_err",    32'((ferr_cnt - e0) + (ovr_cnt - o0)), 32'd0);
    chk("a5_idle",      32'(busy), 32'd0);

    // Glitch shorter than half a bit.
    n0 = rx_log.size(); e0 = ferr_cnt; f0 = cyc;
    frames.push_back('{f0, f0 + GLITCH_AT, K_GLITCH, 8'h00});
    rx = 1'b0;
    hold(30);
    rx = 1'b1;
    hold(200);
    chk("glitch_started", 32'(brise - f0), 32'd3);
    chk("glitch_no_byte", 32'(rx_log.size() - n0), 32'd0);
    chk("glitch_no_ferr", 32'(ferr_cnt - e0), 32'd0);
    chk("glitch_idle",    32'(busy), 32'd0);

    // Framing error, then line held low (break).
    n0 = rx_log.size(); e0 = ferr_cnt; v0 = valid_cyc;
    send_frame(8'h3C, CPB, 1'b0);
    hold(2000);
    chk("ferr_pulses",   32'(ferr_cnt - e0), 32'd1);
    chk("ferr_no_byte",  32'(rx_log.size() - n0), 32'd0);
    chk("ferr_no_valid", 32'(valid_cyc - v0), 32'd0);
    chk("break_idle",    32'(busy), 32'd0);
    rx = 1'b1;
    hold(100);
    chk("break_no_retrigger", 32'(ferr_cnt - e0), 32'd1);

    // Overrun: two frames with ready low.
    ready = 1'b0;
    n0 = rx_log.size(); e0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h11, CPB, 1'b1);
    send_frame(8'h22, CPB, 1'b1);
    hold(100);
    chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_valid",  32'(valid), 32'd1);
    chk("ovr_dat",    32'(dat), 32'h011);
    chk("ovr_no_ferr", 32'(ferr_cnt - e0), 32'd0);
    ready = 1'b1;
    hold(5);
    chk("ovr_drain_count", 32'(rx_log.size() - n0), 32'd1);
    chk("ovr_drain_byte",  32'(log_at(n0)), 32'h011);
    chk("ovr_drain_empty", 32'(valid), 32'd0);
    hold(50);

    // Back-to-back with -3% / +3% / -3% line period and zero idle.
    n0 = rx_log.size(); e0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h00, 97, 1'b1);
    send_frame(8'hFF, 103, 1'b1);
    send_frame(8'h55, 97, 1'b1);
    hold(200);
    chk("b2b_count",  32'(rx_log.size() - n0), 32'd3);
    chk("b2b_byte0",  32'(log_at(n0)),     32'h000);
    chk("b2b_byte1",  32'(log_at(n0 + 1)), 32'h0FF);
    chk("b2b_byte2",  32'(log_at(n0 + 2)), 32'h055);
    chk("b2b_no_err", 32'((ferr_cnt - e0) + (ovr_cnt - o0)), 32'd0);

    // Reset during data bit 4 with a byte waiting in the holding register.
    ready = 1'b0;
    send_frame(8'h33, CPB, 1'b1);
    hold(50);
    chk("pre_rst_valid", 32'(valid), 32'd1);
    chk("pre_rst_dat",   32'(dat), 32'h033);
    pb = 8'h96;
    f0 = cyc;
    frames.push_back('{f0, f0 + STOP_AT, K_BYTE, pb});
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = pb[i];
      hold(CPB);
    end
    rx = pb[4];
    hold(40);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_busy",  32'(busy),  32'd0);
    chk("async_rst_dat",   32'(dat),   32'd0);
    chk("async_rst_ferr",  32'(ferr),  32'd0);
    chk("async_rst_ovr",   32'(ovr),   32'd0);
    rx = 1'b1;
    hold(5);
    rst_n = 1'b1;
    hold(20);
    ready = 1'b1;
    n0 = rx_log.size(); e0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h7E, CPB, 1'b1);
    hold(200);
    chk("post_rst_count",  32'(rx_log.size() - n0), 32'd1);
    chk("post_rst_byte",   32'(log_at(n0)), 32'h07E);
    chk("post_rst_no_err", 32'((ferr_cnt - e0) + (ovr_cnt - o0)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
